// File: rtl/vga_sync_monitor.sv
// Receiver for a low-active H_sync/V_sync VGA timing stream. It recovers the pixel
// position and display enable, measures line/frame timing, and tracks lock.
module vga_sync_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 521,
    parameter int H_SYNC      = 96,
    parameter int V_SYNC      = 2,
    parameter int H_ACT_FIRST = 144,
    parameter int H_ACT_LAST  = 783,
    parameter int V_ACT_FIRST = 32,
    parameter int V_ACT_LAST  = 509,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       H_sync,
    input  logic       V_sync,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       de,
    output logic       locked,
    output logic [9:0] h_total_meas,
    output logic [9:0] h_sync_meas,
    output logic [9:0] v_total_meas,
    output logic [9:0] v_sync_meas,
    output logic [7:0] err_cnt
);

    localparam logic [9:0]  CNT_MAX     = 10'd1023;
    localparam logic [10:0] H_TOTAL_L   = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_L   = 11'(V_TOTAL);
    localparam logic [10:0] H_SYNC_L    = 11'(H_SYNC);
    localparam logic [9:0]  V_SYNC_L    = 10'(V_SYNC);
    localparam logic [9:0]  H_FIRST_L   = 10'(H_ACT_FIRST);
    localparam logic [9:0]  H_LAST_L    = 10'(H_ACT_LAST);
    localparam logic [9:0]  V_FIRST_L   = 10'(V_ACT_FIRST);
    localparam logic [9:0]  V_LAST_L    = 10'(V_ACT_LAST);
    localparam logic [7:0]  LOCK_L      = 8'(LOCK_FRAMES);
    localparam logic [7:0]  ERR_MAX     = 8'd255;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        CHECK    = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t     state_reg;
    logic       hs_d;
    logic       vs_d;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] vs_line_cnt;
    logic [7:0] good_cnt;
    logic       frame_ok;

    logic [1:0] sync_now;
    logic [1:0] sync_prev;
    logic [1:0] sync_fall;
    logic [1:0] sync_rise;
    logic       hs_fall;
    logic       hs_rise;
    logic       vs_fall;
    logic       vs_rise;
    logic       frame_start;

    // Edge detection on both syncs; index 0 is H_sync, index 1 is V_sync.
    assign sync_now  = {V_sync, H_sync};
    assign sync_prev = {vs_d, hs_d};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            assign sync_fall[gi] = sync_prev[gi] & ~sync_now[gi];
            assign sync_rise[gi] = ~sync_prev[gi] & sync_now[gi];
        end
    endgenerate

    assign hs_fall     = sync_fall[0];
    assign hs_rise     = sync_rise[0];
    assign vs_fall     = sync_fall[1];
    assign vs_rise     = sync_rise[1];
    assign frame_start = vs_fall & hs_fall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hs_d <= 1'b1;
            vs_d <= 1'b1;
        end else begin
            hs_d <= H_sync;
            vs_d <= V_sync;
        end
    end

    logic [9:0]  h_cnt_inc;
    logic [9:0]  v_cnt_inc;
    logic [9:0]  vs_line_inc;
    logic [10:0] h_cnt_p1;
    logic [10:0] v_cnt_p1;

    assign h_cnt_inc   = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 10'd1;
    assign v_cnt_inc   = (v_cnt == CNT_MAX) ? CNT_MAX : v_cnt + 10'd1;
    assign vs_line_inc = (vs_line_cnt == CNT_MAX) ? CNT_MAX : vs_line_cnt + 10'd1;
    assign h_cnt_p1    = {1'b0, h_cnt} + 11'd1;
    assign v_cnt_p1    = {1'b0, v_cnt} + 11'd1;

    // vs_line_cnt counts line starts seen while V_sync is low, including the frame start itself.
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            vs_line_cnt <= '0;
        end else begin
            h_cnt <= hs_fall ? 10'd0 : h_cnt_inc;
            if (hs_fall) begin
                v_cnt <= vs_fall ? 10'd0 : v_cnt_inc;
            end
            if (vs_fall) begin
                vs_line_cnt <= hs_fall ? 10'd1 : 10'd0;
            end else if (hs_fall && !V_sync) begin
                vs_line_cnt <= vs_line_inc;
            end
        end
    end

    // h_cnt restarts at the sync fall, so at the rise h_cnt+1 is the low width.
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_total_meas <= '0;
            h_sync_meas  <= '0;
            v_total_meas <= '0;
            v_sync_meas  <= '0;
        end else begin
            if (hs_fall) begin
                h_total_meas <= h_cnt_inc;
            end
            if (hs_rise) begin
                h_sync_meas <= h_cnt_inc;
            end
            if (frame_start) begin
                v_total_meas <= v_cnt_inc;
            end
            if (vs_rise) begin
                v_sync_meas <= vs_line_cnt;
            end
        end
    end

    logic err_htot;
    logic err_hsync;
    logic err_vtot;
    logic err_vsync;
    logic err_misalign;
    logic err_loss;
    logic err_any;
    logic err_fatal;

    assign err_htot     = hs_fall & (h_cnt_p1 != H_TOTAL_L);
    assign err_hsync    = hs_rise & (h_cnt_p1 != H_SYNC_L);
    assign err_vtot     = frame_start & (v_cnt_p1 != V_TOTAL_L);
    assign err_vsync    = vs_rise & (vs_line_cnt != V_SYNC_L);
    assign err_misalign = vs_fall & ~hs_fall;
    assign err_loss     = (h_cnt == CNT_MAX);
    assign err_any      = err_htot | err_hsync | err_vtot | err_vsync | err_misalign | err_loss;
    assign err_fatal    = err_misalign | err_loss;

    // A new frame always starts clean; an error in the closing cycle is charged to the old frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_ok <= 1'b0;
        end else if (frame_start) begin
            frame_ok <= 1'b1;
        end else if (err_any) begin
            frame_ok <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= UNLOCKED;
            good_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            case (state_reg)
                UNLOCKED: begin
                    if (frame_start) begin
                        state_reg <= CHECK;
                        good_cnt  <= '0;
                    end
                end
                CHECK: begin
                    if (err_fatal) begin
                        state_reg <= UNLOCKED;
                    end else if (frame_start && frame_ok && !err_any) begin
                        good_cnt <= good_cnt + 8'd1;
                        if (good_cnt + 8'd1 == LOCK_L) begin
                            state_reg <= LOCKED;
                        end
                    end else if (err_any) begin
                        good_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (err_any) begin
                        state_reg <= UNLOCKED;
                        if (err_cnt != ERR_MAX) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= UNLOCKED;
                end
            endcase
        end
    end

    logic h_act;
    logic v_act;

    assign locked = (state_reg == LOCKED);
    assign h_act  = (h_cnt >= H_FIRST_L) && (h_cnt <= H_LAST_L);
    assign v_act  = (v_cnt >= V_FIRST_L) && (v_cnt <= V_LAST_L);
    assign de     = locked & h_act & v_act;
    assign x      = de ? (h_cnt - H_FIRST_L) : 10'd0;
    assign y      = de ? (v_cnt - V_FIRST_L) : 10'd0;

endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

Display-side receiver for the 800x521 VGA timing stream produced by the design's VGA timing generator. It consumes the low-active `H_sync`/`V_sync` pair on the same pixel clock and recovers the pixel position and the display-enable. It measures line and frame timing, checks it against nominal values, and reports lock status. It sits between the timing generator and downstream pixel consumers, such as the snake renderer, and doubles as a self-check for the generator.

## Interface
- `H_TOTAL`, 800, clocks per line
- `V_TOTAL`, 521, lines per frame
- `H_SYNC`, 96, H_sync low width (clocks)
- `V_SYNC`, 2, V_sync low width (lines)
- `H_ACT_FIRST` / `H_ACT_LAST`, 144 / 783, active column bounds (inclusive)
- `V_ACT_FIRST` / `V_ACT_LAST`, 32 / 509, active line bounds (inclusive)
- `LOCK_FRAMES`, 2, consecutive good frames required to lock
- `clk`  in  1  pixel clock
- `rst`  in  1  reset; synchronous, active-low
- `H_sync`  in  1  line sync, low-active, synchronous to `clk`
- `V_sync`  in  1  frame sync, low-active, synchronous to `clk`
- `x`  out  10  active column, `h_cnt-H_ACT_FIRST` when `de`, else 0
- `y`  out  10  active line, `v_cnt-V_ACT_FIRST` when `de`, else 0
- `de`  out  1  recovered display enable; gated by `locked`
- `locked`  out  1  timing locked
- `h_total_meas`, `h_sync_meas`, `v_total_meas`, `v_sync_meas`  out  10 each  last measured values
- `err_cnt`  out  8  count of lock losses, saturating at 255

## Operation
- **Registers:**
  - `hs_d` and `vs_d` hold the previous input values.
  - `hs_fall = hs_d & ~H_sync`.
  - `hs_rise = ~hs_d & H_sync`; `vs_fall` and `vs_rise` are formed the same way.
- **`h_cnt` (10 bit):**
  - Set to 0 on `hs_fall`; otherwise increments, saturating at 1023.
  - After lock, `h_cnt` equals the generator's column count delayed by 1 clk.
- **`v_cnt` (10 bit):**
  - On `hs_fall`: set to 0 if `vs_fall` occurs in the same cycle, else incremented (saturating at 1023).
- **Measurements:**
  - On `hs_fall`: `h_total_meas <= h_cnt+1`.
  - On `hs_rise`: `h_sync_meas <=` clocks `H_sync` was low.
  - On coincident `vs_fall`: `v_total_meas <= v_cnt+1`.
  - On `vs_rise`: `v_sync_meas <=` count of `hs_fall` events seen while `V_sync` was low.
- **Error events:** any of the following, each evaluated in the cycle its edge is sampled:
  - `h_cnt+1 != H_TOTAL` at `hs_fall`;
  - H_sync width `!= H_SYNC` at `hs_rise`;
  - `v_cnt+1 != V_TOTAL` at coincident `vs_fall`;
  - V_sync width `!= V_SYNC` at `vs_rise`;
  - `vs_fall` without `hs_fall` (misalignment);
  - `h_cnt` reaching 1023 (sync loss).
- **Per-frame flag:** `frame_ok` is set at each coincident `vs_fall` and cleared by any error event.
- **FSM states:**
  - **UNLOCKED:** go to CHECK on `vs_fall & hs_fall`, with `good_cnt=0`.
  - **CHECK:**
    - At each coincident `vs_fall`, if the closing frame has `frame_ok` with no error this cycle: `good_cnt++`. Go to LOCKED when `good_cnt+1 == LOCK_FRAMES`.
    - A misaligned `vs_fall`, or sync loss: return to UNLOCKED.
    - Any other error: `good_cnt <= 0`, stay in CHECK.
  - **LOCKED:** any error event goes to UNLOCKED and increments `err_cnt` (saturating).
- **Outputs:**
  - `locked = (state == LOCKED)`.
  - `de = locked & H_ACT_FIRST <= h_cnt <= H_ACT_LAST & V_ACT_FIRST <= v_cnt <= V_ACT_LAST`.
  - `x`, `y`, `de` are combinational from registered counters; no extra pipeline stage.

## Timing
- **Reset:**
  - `rst=0` at a `clk` edge resets all registers.
  - `hs_d`/`vs_d` reset to 1, so a sync already low at reset release is seen as a falling edge.
  - Every other register, and therefore every output, resets to 0; state resets to UNLOCKED.
- **Reset mid-frame:** measurements and `err_cnt` are discarded.
- **Latency:** `h_cnt`/`v_cnt` lag the source by 1 clk. `de` therefore aligns with the generator's registered display-valid signal.
- **Lock/unlock visibility:**
  - `locked` falls at the edge after the error-event cycle.
  - `de`, `x` and `y` read 0 in that same cycle.
- **Simultaneous events:**
  - Coincident `vs_fall`+`hs_fall` is the only valid frame start.
  - An error in the same cycle as the frame close counts against the closing frame.

## Test plan
- **Nominal lock:** drive the generator from reset released together with this block.
  - `locked` becomes 1 after the `vs_fall` at clk 833600 (two frames of 416800).
  - Measurements read 800 / 96 / 521 / 2; `err_cnt=0`.
- **Display enable and coordinates:** once locked, `de` equals the generator's display-valid output every cycle.
  - First active pixel: `x=0`, `y=0`.
  - Last active pixel: `x=639`, `y=477`.
  - `x`, `y` read 0 outside the active area.
- **Long line:** stretch one line to 801 clocks while locked.
  - At that `hs_fall`: `h_total_meas=801`, `locked` falls next edge, `err_cnt=1`.
  - Relock occurs after two following good frames.
- **Sync loss:** hold `H_sync` high while locked.
  - `h_cnt` saturates at 1023; unlock occurs; `err_cnt` increments.
  - On restoring the sync, CHECK is entered at the next frame start.
- **Misaligned V_sync:** in CHECK, drop `V_sync` 5 clks after `hs_fall` → state returns to UNLOCKED and `locked` stays 0.
- **Mid-frame reset:** hold `rst=0` for 1 clk mid-frame → the next edge shows all outputs 0, `hs_d`/`vs_d` = 1, and lock is reacquired normally.
